// File: rtl/add_sub_pipe_pkg.sv
// Shared constants and operation encoding for the pipelined adder/subtractor.
package add_sub_pipe_pkg;

    localparam int unsigned DEF_WIDTH  = 16;
    localparam int unsigned DEF_STAGES = 4;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } op_e;

endpackage

// File: rtl/add_sub_pipe_stage.sv
// One pipeline slice: adds its WIDTH/STAGES bits with the carry from the previous
// slice and registers the beat; the last slice also produces the Ovf/Zero flags.
module add_sub_stage
    import add_sub_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned STAGES = DEF_STAGES,
    parameter int unsigned IDX    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic             c_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o,
    output logic             ovf_o,
    output logic             zero_o
);

    localparam int unsigned SL = WIDTH / STAGES;
    localparam int unsigned LO = IDX * SL;

    logic             valid_q;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             c_q;
    logic [SL:0]      slice_sum;
    logic [WIDTH-1:0] s_d;
    logic             load;

    always_comb begin
        slice_sum = {1'b0, a_i[LO +: SL]} + {1'b0, b_i[LO +: SL]} + {{SL{1'b0}}, c_i};
        s_d       = s_i;
        s_d[LO +: SL] = slice_sum[SL-1:0];
    end

    // Accept when empty or when the held beat leaves this cycle.
    assign ready_o = !valid_q || ready_i;
    assign load    = valid_i && ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
        end else begin
            if (ready_o) valid_q <= valid_i;
            if (load) begin
                a_q <= a_i;
                b_q <= b_i;
                s_q <= s_d;
                c_q <= slice_sum[SL];
            end
        end
    end

    assign valid_o = valid_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign s_o     = s_q;
    assign c_o     = c_q;

    if (IDX == STAGES - 1) begin : g_flags
        logic ovf_q, zero_q;
        logic ovf_d, zero_d;

        // Operands of equal sign producing a result of the other sign is exactly
        // the MSB carry-in/carry-out disagreement (b_i is already inverted for SUB).
        always_comb begin
            ovf_d  = (a_i[WIDTH-1] ~^ b_i[WIDTH-1]) & (s_d[WIDTH-1] ^ a_i[WIDTH-1]);
            zero_d = (s_d == '0);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ovf_q  <= 1'b0;
                zero_q <= 1'b0;
            end else if (load) begin
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end

        assign ovf_o  = ovf_q;
        assign zero_o = zero_q;
    end else begin : g_no_flags
        assign ovf_o  = 1'b0;
        assign zero_o = 1'b0;
    end

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor with valid/ready handshake; one slice of
// the carry chain per stage, results emerge in acceptance order.
module add_sub_pipe
    import add_sub_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    logic             en_q;
    logic             v_p   [0:STAGES];
    logic             r_p   [0:STAGES];
    logic [WIDTH-1:0] a_p   [0:STAGES];
    logic [WIDTH-1:0] b_p   [0:STAGES];
    logic [WIDTH-1:0] s_p   [0:STAGES];
    logic             c_p   [0:STAGES];
    logic             ovf_p [0:STAGES-1];
    logic             zero_p[0:STAGES-1];
    logic             unused_tail;

    // Holds in_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_q <= 1'b0;
        else        en_q <= 1'b1;
    end

    assign v_p[0]      = in_valid && en_q;
    assign in_ready    = en_q && r_p[0];
    assign a_p[0]      = A;
    assign b_p[0]      = (op_e'(Sub) == SUB) ? ~B : B;
    assign s_p[0]      = '0;
    assign c_p[0]      = (op_e'(Sub) == SUB) ? 1'b1 : Cin;
    assign r_p[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        add_sub_stage #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES),
            .IDX    (k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (v_p[k]),
            .ready_o (r_p[k]),
            .a_i     (a_p[k]),
            .b_i     (b_p[k]),
            .s_i     (s_p[k]),
            .c_i     (c_p[k]),
            .valid_o (v_p[k+1]),
            .ready_i (r_p[k+1]),
            .a_o     (a_p[k+1]),
            .b_o     (b_p[k+1]),
            .s_o     (s_p[k+1]),
            .c_o     (c_p[k+1]),
            .ovf_o   (ovf_p[k]),
            .zero_o  (zero_p[k])
        );
    end

    assign out_valid = v_p[STAGES];
    assign S         = s_p[STAGES];
    assign Cout      = c_p[STAGES];
    assign Ovf       = ovf_p[STAGES-1];
    assign Zero      = zero_p[STAGES-1];

    always_comb begin
        unused_tail = ^{a_p[STAGES], b_p[STAGES]};
        for (int unsigned k = 0; k < STAGES - 1; k++) begin
            unused_tail = unused_tail ^ ovf_p[k] ^ zero_p[k];
        end
    end

endmodule

// File: tb/tb_add_sub_pipe.sv
// Self-checking bench for add_sub_pipe: directed vectors, streaming sweep,
// backpressure and mid-flight reset, all checked through an in-order scoreboard.
module tb_add_sub_pipe;

    typedef struct packed {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        res_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] A, B;
    logic        Cin, Sub;
    logic        out_valid, out_ready;
    logic [15:0] S;
    logic        Cout, Ovf, Zero;

    res_t sb_q[$];
    res_t cur_exp;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   out_cnt = 0;
    int   mark = -1;
    int   first_out_cyc = 0;
    int   last_out_cyc = 0;

    add_sub_pipe #(
        .WIDTH  (16),
        .STAGES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sub       (Sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .Ovf       (Ovf),
        .Zero      (Zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        res_t        m;
        int          sa, sbv, r;
        logic [16:0] u;
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (sub) begin
            r      = sa - sbv;
            u      = {1'b0, a} - {1'b0, b};
            m.cout = ({1'b0, a} >= {1'b0, b});
        end else begin
            r      = sa + sbv + int'(cin);
            u      = {1'b0, a} + {1'b0, b} + 17'(cin);
            m.cout = u[16];
        end
        m.s    = u[15:0];
        m.ovf  = (r > 32767) || (r < -32768);
        m.zero = (u[15:0] == 16'h0000);
        return m;
    endfunction

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                input logic sub, input logic [15:0] s, input logic co,
                                input logic ov, input logic z);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.exp.s = s; v.exp.cout = co; v.exp.ovf = ov; v.exp.zero = z;
        return v;
    endfunction

    // Output side compares first, then the input side records an accepted beat.
    always @(negedge clk) begin
        res_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got S=0x%0h expected no beat", S);
            end else begin
                e = sb_q.pop_front();
                check("out_S",    32'(S),    32'(e.s));
                check("out_Cout", 32'(Cout), 32'(e.cout));
                check("out_Ovf",  32'(Ovf),  32'(e.ovf));
                check("out_Zero", 32'(Zero), 32'(e.zero));
            end
            if (out_cnt == mark) first_out_cyc = cyc;
            out_cnt++;
            last_out_cyc = cyc;
        end
        if (rst_n && in_valid && in_ready) sb_q.push_back(cur_exp);
    end

    task automatic send(input vec_t v);
        logic ok;
        A = v.a; B = v.b; Cin = v.cin; Sub = v.sub;
        cur_exp  = v.exp;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 64 cycles");
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        A   = 16'($urandom);
        B   = 16'($urandom);
        Cin = 1'($urandom);
        Sub = 1'($urandom);
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && sb_q.size() > 0; n++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        vec_t v;
        res_t held;
        int   drive_cyc, lat, n_sweep, cnt0;
        logic seen;

        tbl[0] = mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        tbl[1] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        tbl[2] = mk(16'hFFFF, 16'h8000, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        tbl[3] = mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        tbl[4] = mk(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        tbl[5] = mk(16'h1234, 16'h0001, 1'b1, 1'b0, 16'h1236, 1'b0, 1'b0, 1'b0);
        tbl[6] = mk(16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        tbl[7] = mk(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        tbl[8] = mk(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b0; out_ready = 1'b1;
        idle();
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_S",         32'(S),         32'd0);
        check("rst_flags",     32'({Cout, Ovf, Zero}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("in_ready_after_edge", 32'(in_ready), 32'd1);

        // Single beat: latency from the drive cycle to out_valid.
        drive_cyc = cyc;
        send(tbl[0]);
        idle();
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = out_valid;
        end
        lat = cyc - drive_cyc;
        check("latency", 32'(lat), 32'd4);
        drain();

        for (int i = 0; i < 9; i++) send(tbl[i]);
        idle();
        drain();

        // Streaming sweep, one beat per cycle.
        mark    = out_cnt;
        n_sweep = 0;
        for (int a = -100; a < 100; a += 20) begin
            for (int b = -100; b < 100; b += 2) begin
                v.a   = 16'(a);
                v.b   = 16'(b);
                v.sub = 1'((b / 2) & 1);
                v.cin = 1'(((a / 20) ^ (b / 4)) & 1);
                v.exp = model(v.a, v.b, v.cin, v.sub);
                send(v);
                n_sweep++;
            end
        end
        idle();
        drain();
        check("sweep_count", 32'(out_cnt - mark), 32'(n_sweep));
        check("sweep_throughput", 32'(last_out_cyc - first_out_cyc + 1), 32'(n_sweep));
        mark = -1;

        // Backpressure: fill, stall six cycles, then accept and consume together.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            v.a = 16'h1111 * 16'(k + 1); v.b = 16'h0101 * 16'(k + 3);
            v.cin = 1'(k); v.sub = 1'(k >> 1);
            v.exp = model(v.a, v.b, v.cin, v.sub);
            send(v);
        end
        v.a = 16'hABCD; v.b = 16'h1234; v.cin = 1'b0; v.sub = 1'b1;
        v.exp = model(v.a, v.b, v.cin, v.sub);
        A = v.a; B = v.b; Cin = v.cin; Sub = v.sub; cur_exp = v.exp; in_valid = 1'b1;
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        held = sb_q[0];
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready",  32'(in_ready),  32'd0);
            check("stall_S_held",    32'(S),         32'(held.s));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        check("accept_and_consume", 32'({in_ready, out_valid}), 32'b11);
        @(posedge clk);
        #1;
        idle();
        drain();

        // Reset with three beats in flight.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            v.a = 16'h0F00 + 16'(k); v.b = 16'h00F0; v.cin = 1'b0; v.sub = 1'b0;
            v.exp = model(v.a, v.b, v.cin, v.sub);
            send(v);
        end
        idle();
        repeat (3) @(posedge clk);
        #2;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_S",         32'(S),         32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cnt0 = out_cnt;
        repeat (12) @(posedge clk);
        #1;
        check("no_stale_beats", 32'(out_cnt - cnt0), 32'd0);
        send(tbl[5]);
        idle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
